// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of the 8-bit fifo
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  input  logic           fifo_full,
  output logic           fifo_wr_en,
  output logic [W-1:0]   fifo_data_in,
  output logic [2:0]     owner,
  output logic           busy,
  output logic [15:0]    wr_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  beats_q, beats_d;
  logic [2:0]  owner_q, owner_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic          win_found;
  logic [2:0]    win_idx;
  int            idx;
  logic [N-1:0]  gnt_int;
  logic [W-1:0]  data_mux;

  // Index following i, wrapping back to requester 0 after N-1.
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    if (i == 3'(N - 1)) return 3'd0;
    return i + 3'd1;
  endfunction

  // Round-robin search: first requester with req=1 starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = 3'(idx);
      end
    end
  end

  // Next-state and grant decode; a full FIFO freezes everything and blocks grants.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    beats_d  = beats_q;
    owner_d  = owner_q;
    gnt_int  = '0;
    if (!fifo_full) begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_int[win_idx[IW-1:0]] = 1'b1;
            if (BURST == 1) begin
              rr_ptr_d = next_idx(win_idx);
            end else begin
              state_d = OWN;
              owner_d = win_idx;
              beats_d = 4'd1;
            end
          end
        end
        OWN: begin
          if (req[owner_q[IW-1:0]]) begin
            gnt_int[owner_q[IW-1:0]] = 1'b1;
            beats_d = beats_q + 4'd1;
            if (beats_d == 4'(BURST)) begin
              state_d  = IDLE;
              beats_d  = 4'd0;
              rr_ptr_d = next_idx(owner_q);
            end
          end else begin
            // Owner dropped its request: give up the burst with a one-cycle bubble.
            state_d  = IDLE;
            beats_d  = 4'd0;
            rr_ptr_d = next_idx(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (reset) gnt_int = '0;
  end

  // Write-port mux: data of the granted requester, zero when nobody is granted.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_int[i]) data_mux = req_data[i*W +: W];
    end
  end

  // Beat counter saturating at all-ones.
  always_comb begin
    wr_count_d = wr_count_q;
    if ((|gnt_int) && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 3'd0;
      beats_q    <= 4'd0;
      owner_q    <= 3'd0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beats_q    <= beats_d;
      owner_q    <= owner_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign gnt          = gnt_int;
  assign fifo_wr_en   = |gnt_int;
  assign fifo_data_in = data_mux;
  assign owner        = owner_q;
  assign busy         = (state_q == OWN);
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int BURST = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [2:0]     owner;
  logic           busy;
  logic [15:0]    wr_count;

  int checks;
  int failures;

  fifo_wr_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .owner(owner), .busy(busy), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a burst is either in progress for a given requester or not.
  int m_ptr;
  int m_owner;
  int m_beats;
  bit m_in_burst;
  int m_cnt;

  function automatic void model_reset();
    m_ptr = 0; m_owner = 0; m_beats = 0; m_in_burst = 0; m_cnt = 0;
  endfunction

  function automatic int model_winner(input logic [N-1:0] r, input logic full);
    if (full) return -1;
    if (m_in_burst) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic full);
    int g;
    g = model_winner(r, full);
    if (full) return;
    if (g >= 0 && m_cnt < 65535) m_cnt++;
    if (!m_in_burst) begin
      if (g >= 0) begin
        if (BURST == 1) m_ptr = (g + 1) % N;
        else begin m_in_burst = 1; m_owner = g; m_beats = 1; end
      end
    end else if (g >= 0) begin
      m_beats++;
      if (m_beats == BURST) begin m_in_burst = 0; m_ptr = (m_owner + 1) % N; end
    end else begin
      m_in_burst = 0;
      m_ptr = (m_owner + 1) % N;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int g;
    logic [N*W-1:0] rd;
    logic [31:0] exp_gnt;
    logic [31:0] exp_data;
    rd = req_data;
    g = model_winner(req, fifo_full);
    exp_gnt  = (g >= 0) ? (32'd1 << g) : 32'd0;
    exp_data = (g >= 0) ? 32'(rd[g*W +: W]) : 32'd0;
    chk("m_gnt", 32'(gnt), exp_gnt);
    chk("m_wr_en", 32'(fifo_wr_en), (g >= 0) ? 32'd1 : 32'd0);
    chk("m_data", 32'(fifo_data_in), exp_data);
    chk("m_busy", 32'(busy), 32'(m_in_burst));
    if (m_in_burst) chk("m_owner", 32'(owner), 32'(m_owner));
    chk("m_wr_count", 32'(wr_count), 32'(m_cnt));
  endtask

  // Apply inputs at the falling edge and check combinational outputs shortly after.
  task automatic set_in(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic f);
    req = r; req_data = d; fifo_full = f;
    #1;
    model_check();
  endtask

  task automatic tick();
    model_step(req, fifo_full);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b1111; req_data = 32'hD4C3B2A1; fifo_full = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data", 32'(fifo_data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    @(posedge clk); #1;
    chk("rst_gnt_edge", 32'(gnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] gnt;
    logic [W-1:0] data;
    logic         busy;
    logic [15:0]  cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();

    vecs[0] = '{4'b1111, 1'b0, 4'b0001, 8'hA1, 1'b0, 16'd0};
    vecs[1] = '{4'b1111, 1'b0, 4'b0001, 8'hA1, 1'b1, 16'd1};
    vecs[2] = '{4'b1111, 1'b0, 4'b0010, 8'hB2, 1'b0, 16'd2};
    vecs[3] = '{4'b1111, 1'b0, 4'b0010, 8'hB2, 1'b1, 16'd3};
    vecs[4] = '{4'b1111, 1'b0, 4'b0100, 8'hC3, 1'b0, 16'd4};
    vecs[5] = '{4'b1111, 1'b0, 4'b0100, 8'hC3, 1'b1, 16'd5};
    vecs[6] = '{4'b1111, 1'b0, 4'b1000, 8'hD4, 1'b0, 16'd6};
    vecs[7] = '{4'b1111, 1'b0, 4'b1000, 8'hD4, 1'b1, 16'd7};
    vecs[8] = '{4'b1111, 1'b0, 4'b0001, 8'hA1, 1'b0, 16'd8};

    @(negedge clk);
    do_reset();

    // Full rotation from requester 0 with two-beat bursts.
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].req, 32'hD4C3B2A1, vecs[i].full);
      chk($sformatf("tab_gnt[%0d]", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("tab_data[%0d]", i), 32'(fifo_data_in), 32'(vecs[i].data));
      chk($sformatf("tab_busy[%0d]", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("tab_cnt[%0d]", i), 32'(wr_count), 32'(vecs[i].cnt));
      tick();
    end

    // Lone requester is granted every cycle; busy alternates between bursts.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(4'b0100, 32'h00550000, 1'b0);
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_data", 32'(fifo_data_in), 32'h55);
      chk("single_busy", 32'(busy), 32'(k % 2));
      tick();
    end
    set_in(4'b0000, 32'h0, 1'b0);
    chk("single_busy_last", 32'(busy), 32'd1);
    tick();

    // Owner drop costs one bubble, then the next requester wins.
    do_reset();
    set_in(4'b0010, 32'h0000AA00, 1'b0);
    chk("drop_gnt0", 32'(gnt), 32'h2);
    tick();
    set_in(4'b1000, 32'hBB000000, 1'b0);
    chk("drop_busy", 32'(busy), 32'd1);
    chk("drop_owner", 32'(owner), 32'd1);
    chk("drop_bubble", 32'(gnt), 32'd0);
    tick();
    set_in(4'b1000, 32'hBB000000, 1'b0);
    chk("drop_gnt3", 32'(gnt), 32'h8);
    tick();

    // Backpressure mid-burst holds the owner and its remaining beat.
    do_reset();
    set_in(4'b0011, 32'h00002211, 1'b0);
    chk("bp_gnt0", 32'(gnt), 32'h1);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(4'b0011, 32'h00002211, 1'b1);
      chk("bp_full_gnt", 32'(gnt), 32'd0);
      chk("bp_full_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("bp_full_busy", 32'(busy), 32'd1);
      chk("bp_full_owner", 32'(owner), 32'd0);
      tick();
    end
    set_in(4'b0011, 32'h00002211, 1'b0);
    chk("bp_resume_gnt", 32'(gnt), 32'h1);
    tick();
    set_in(4'b0011, 32'h00002211, 1'b0);
    chk("bp_next_gnt", 32'(gnt), 32'h2);
    tick();

    // Asynchronous reset in the middle of requester 1's burst.
    do_reset();
    set_in(4'b0001, 32'h00000077, 1'b0);
    tick();
    set_in(4'b0001, 32'h00000077, 1'b0);
    tick();
    set_in(4'b0011, 32'h00008877, 1'b0);
    chk("arst_pre_gnt", 32'(gnt), 32'h2);
    tick();
    set_in(4'b0011, 32'h00008877, 1'b0);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("arst_data", 32'(fifo_data_in), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    set_in(4'b0011, 32'h00008877, 1'b0);
    chk("arst_restart_gnt", 32'(gnt), 32'h1);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      set_in(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 4) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
